// File: rtl/mux4_rr_arbiter.sv
// Purpose: round-robin arbiter sharing one 4:1 mux among four level-sensitive requesters.
// Latency: req to gnt/sel is one cycle; handoff between requesters happens with no idle cycle.
// Backpressure: en=0 blocks new grants; a holder is forced off after HOLD_MAX cycles only if another request waits.
module mux4_rr_arbiter #(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       en,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t           state;
    logic [1:0]       ptr;
    logic [1:0]       w;
    logic [CNT_W-1:0] cnt;

    logic [3:0]       cand;
    logic [3:0]       cand_ex;
    logic [1:0]       w_next_idx;
    logic             idle_found;
    logic [1:0]       idle_k;
    logic             hand_found;
    logic [1:0]       hand_k;
    logic             at_limit;

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

    // Cyclic first-set search starting at index s; returns {found, index}.
    function automatic logic [2:0] rr_find(input logic [3:0] c, input logic [1:0] s);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = s + 2'(i);
            if (c[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Candidate vectors and both winner searches (from ptr when idle, from w+1 when leaving a grant).
    always_comb begin
        cand       = req & {4{en}};
        cand_ex    = cand & ~(4'b0001 << w);
        w_next_idx = w + 2'd1;
        {idle_found, idle_k} = rr_find(cand, ptr);
        {hand_found, hand_k} = rr_find(cand_ex, w_next_idx);
        at_limit   = (cnt == HOLD_LIM);
    end

    // Arbitration FSM with registered grant, select and busy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 2'd0;
            w     <= 2'd0;
            cnt   <= '0;
            gnt   <= 4'b0000;
            sel   <= 2'd0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (idle_found) begin
                        state <= GRANT;
                        w     <= idle_k;
                        sel   <= idle_k;
                        gnt   <= 4'b0001 << idle_k;
                        cnt   <= CNT_W'(1);
                        busy  <= 1'b1;
                    end
                end
                GRANT: begin
                    if (!req[w] || (at_limit && hand_found)) begin
                        // Release (takes precedence) or forced handoff: rotate past the holder.
                        ptr <= w_next_idx;
                        if (hand_found) begin
                            w    <= hand_k;
                            sel  <= hand_k;
                            gnt  <= 4'b0001 << hand_k;
                            cnt  <= CNT_W'(1);
                            busy <= 1'b1;
                        end else begin
                            state <= IDLE;
                            gnt   <= 4'b0000;
                            busy  <= 1'b0;
                            cnt   <= '0;
                        end
                    end else if (!at_limit) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 4'b0000;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       en;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic [7:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] cur_tag;

    mux4_rr_arbiter #(.HOLD_MAX(4), .CNT_W(3)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .en   (en),
        .gnt  (gnt),
        .sel  (sel),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs and queue the outputs expected after the next rising edge.
    task automatic step(input logic r, input logic [3:0] rq, input logic e,
                        input logic [3:0] eg, input logic [1:0] es, input logic eb);
        exp_t x;
        @(negedge clk);
        rst = r;
        req = rq;
        en  = e;
        x.gnt  = eg;
        x.sel  = es;
        x.busy = eb;
        x.tag  = cur_tag;
        exp_q.push_back(x);
    endtask

    // Monitor: after every rising edge, pop one expectation and compare, plus invariant checks.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            checks++;
            if (gnt !== x.gnt || sel !== x.sel || busy !== x.busy) begin
                failures++;
                $display("FAIL outputs phase=%0d got gnt=%b sel=%0d busy=%b expected gnt=%b sel=%0d busy=%b",
                         x.tag, gnt, sel, busy, x.gnt, x.sel, x.busy);
            end
            checks++;
            if ((busy !== (|gnt)) || ((gnt & (gnt - 4'd1)) != 4'd0) || (busy && gnt[sel] !== 1'b1)) begin
                failures++;
                $display("FAIL invariant phase=%0d got gnt=%b sel=%0d busy=%b", x.tag, gnt, sel, busy);
            end
        end
    end

    initial begin
        int waited;
        rst = 1'b1;
        req = 4'b0000;
        en  = 1'b0;

        // Reset with full requests pending, then release: grant 0 one cycle later.
        cur_tag = 8'd1;
        step(1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0);
        step(1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0);

        // Full contention: 0,1,2,3,0 for exactly 4 cycles each, no gaps.
        cur_tag = 8'd2;
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 4; c++) begin
                logic [1:0] k;
                k = 2'(g % 4);
                step(1'b0, 4'b1111, 1'b1, 4'b0001 << k, k, 1'b1);
            end
        end

        // Single requester held past the hold limit, then released; sel holds.
        cur_tag = 8'd3;
        step(1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
        for (int c = 0; c < 10; c++) step(1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1);
        step(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0);
        step(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0);

        // Early release with wrap: ptr=3 after releasing 2, so 3 wins; dropping it hands to 0.
        cur_tag = 8'd4;
        step(1'b0, 4'b1001, 1'b1, 4'b1000, 2'd3, 1'b1);
        step(1'b0, 4'b1001, 1'b1, 4'b1000, 2'd3, 1'b1);
        step(1'b0, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1);
        step(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);

        // Enable gating: no grant while en=0; ptr=1 so 1 wins; en=0 keeps the grant; release finds no winner.
        cur_tag = 8'd5;
        for (int c = 0; c < 5; c++) step(1'b0, 4'b0110, 1'b0, 4'b0000, 2'd0, 1'b0);
        step(1'b0, 4'b0110, 1'b1, 4'b0010, 2'd1, 1'b1);
        for (int c = 0; c < 6; c++) step(1'b0, 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1);
        step(1'b0, 4'b0100, 1'b0, 4'b0000, 2'd1, 1'b0);
        step(1'b0, 4'b0100, 1'b0, 4'b0000, 2'd1, 1'b0);

        // Mid-grant reset: grant 2 to cnt=3, reset clears, then ptr=0 means 0 wins.
        cur_tag = 8'd6;
        for (int c = 0; c < 3; c++) step(1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1);
        step(1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0);
        step(1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1);
        step(1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1);

        // Drain the scoreboard with a bounded wait.
        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
